// File: rtl/rv32e_wb_arbiter.sv
// rtl/rv32e_wb_arbiter.sv - RV32E writeback arbiter with long-latency FIFO and scoreboard
// Pipeline results always win the single register-file write port; buffered long-latency results fill idle slots.
module rv32e_wb_arbiter #(
  parameter int NUM_REGS      = 16,
  parameter int LL_FIFO_DEPTH = 2,
  parameter int CNT_W         = $clog2(LL_FIFO_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pipe_wen,
  input  logic [4:0]       pipe_rd,
  input  logic [31:0]      pipe_data,
  input  logic             ll_valid,
  input  logic [4:0]       ll_rd,
  input  logic [31:0]      ll_data,
  output logic             ll_ready,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_wen,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_w_data,
  output logic             illegal_rd,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = (LL_FIFO_DEPTH > 1) ? $clog2(LL_FIFO_DEPTH) : 1;

  function automatic logic is_real(input logic [4:0] rd);
    return (rd != 5'd0) && !rd[4];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LL_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [3:0]          rd_mem   [LL_FIFO_DEPTH];
  logic [31:0]         data_mem [LL_FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                rf_wen_q, rf_wen_d;
  logic [4:0]          rf_rd_q, rf_rd_d;
  logic [31:0]         rf_data_q, rf_data_d;
  logic                illegal_q, illegal_d;

  logic                pipe_real;
  logic                ll_fire;
  logic                enq;
  logic                pop;
  logic [3:0]          head_rd;
  logic [31:0]         head_data;

  assign ll_ready  = nRST & (count_q < CNT_W'(LL_FIFO_DEPTH));
  assign pipe_real = pipe_wen & is_real(pipe_rd);
  assign ll_fire   = ll_valid & ll_ready;
  assign enq       = ll_fire & is_real(ll_rd);
  assign pop       = !pipe_real && (count_q != '0);
  assign head_rd   = rd_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q + CNT_W'(enq) - CNT_W'(pop);
    illegal_d = (pipe_wen & pipe_rd[4]) | (ll_fire & ll_rd[4]);

    rf_wen_d  = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (pipe_real) begin
      rf_wen_d  = 1'b1;
      rf_rd_d   = pipe_rd;
      rf_data_d = pipe_data;
    end else if (pop) begin
      rf_wen_d  = 1'b1;
      rf_rd_d   = {1'b0, head_rd};
      rf_data_d = head_data;
    end

    // Clear first so a same-cycle issue to the popped register keeps it busy.
    sb_d = sb_q;
    if (pop) sb_d[head_rd] = 1'b0;
    if (iss_valid && is_real(iss_rd)) sb_d[iss_rd[3:0]] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sb_q      <= '0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sb_q      <= sb_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      rd_mem[wr_ptr_q]   <= ll_rd[3:0];
      data_mem[wr_ptr_q] <= ll_data;
    end
  end

  assign rs1_busy   = is_real(rs1) & sb_q[rs1[3:0]];
  assign rs2_busy   = is_real(rs2) & sb_q[rs2[3:0]];
  assign rf_wen     = rf_wen_q;
  assign rf_rd      = rf_rd_q;
  assign rf_w_data  = rf_data_q;
  assign illegal_rd = illegal_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rv32e_wb_arbiter.sv
// tb/tb_rv32e_wb_arbiter.sv - directed self-checking bench for rv32e_wb_arbiter
module tb_rv32e_wb_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_w_data;
  logic        illegal_rd;
  logic [1:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  rv32e_wb_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_w_data(rf_w_data),
    .illegal_rd(illegal_rd), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    pipe_wen = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    #1;
  endtask

  task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
    pipe_wen = 1'b1; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic ll(input logic [4:0] rd, input logic [31:0] d);
    ll_valid = 1'b1; ll_rd = rd; ll_data = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
  endtask

  initial begin
    nRST = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    idle();
    tick(); tick();
    check("rst_ll_ready", 32'(ll_ready), 32'd0);
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_rf_rd", 32'(rf_rd), 32'd0);
    check("rst_rf_data", rf_w_data, 32'd0);
    check("rst_illegal", 32'(illegal_rd), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    nRST = 1'b1; #1;
    check("post_rst_ready", 32'(ll_ready), 32'd1);

    // Pipeline write
    pipe(5'd5, 32'hDEADBEEF); tick(); idle(); rs1 = 5'd5; #1;
    check("pipe_wen", 32'(rf_wen), 32'd1);
    check("pipe_rd", 32'(rf_rd), 32'd5);
    check("pipe_data", rf_w_data, 32'hDEADBEEF);
    check("pipe_no_busy", 32'(rs1_busy), 32'd0);

    // LL round trip
    issue(5'd3); tick(); idle(); rs1 = 5'd3; #1;
    check("iss_busy", 32'(rs1_busy), 32'd1);
    ll(5'd3, 32'h1234); #1;
    check("ll_ready_empty", 32'(ll_ready), 32'd1);
    tick(); idle();
    check("ll_lat1_wen", 32'(rf_wen), 32'd0);
    check("ll_lat1_count", 32'(fifo_count), 32'd1);
    check("ll_lat1_busy", 32'(rs1_busy), 32'd1);
    tick();
    check("ll_wen", 32'(rf_wen), 32'd1);
    check("ll_rd", 32'(rf_rd), 32'd3);
    check("ll_data", rf_w_data, 32'h1234);
    check("ll_busy_clr", 32'(rs1_busy), 32'd0);
    check("ll_count0", 32'(fifo_count), 32'd0);

    // Contention: pipe x1..x3 holds off pops while the FIFO fills
    pipe(5'd1, 32'h11); ll(5'd6, 32'hA); tick();
    check("ct_x1_rd", 32'(rf_rd), 32'd1);
    check("ct_count1", 32'(fifo_count), 32'd1);
    pipe(5'd2, 32'h22); ll(5'd7, 32'hB); tick();
    ll_valid = 1'b0; #1;
    check("ct_x2_rd", 32'(rf_rd), 32'd2);
    check("ct_count2", 32'(fifo_count), 32'd2);
    check("ct_full_ready", 32'(ll_ready), 32'd0);
    pipe(5'd3, 32'h33); ll(5'd8, 32'hC); tick(); idle();
    check("ct_x3_data", rf_w_data, 32'h33);
    check("ct_refused", 32'(fifo_count), 32'd2);
    tick();
    check("ct_x6_wen", 32'(rf_wen), 32'd1);
    check("ct_x6_rd", 32'(rf_rd), 32'd6);
    check("ct_x6_data", rf_w_data, 32'hA);
    tick();
    check("ct_x7_rd", 32'(rf_rd), 32'd7);
    check("ct_x7_data", rf_w_data, 32'hB);
    check("ct_count0", 32'(fifo_count), 32'd0);
    tick();
    check("ct_drained", 32'(rf_wen), 32'd0);

    // Illegal and x0 destinations
    pipe(5'd17, 32'h5); tick(); idle();
    check("ill_pipe_wen", 32'(rf_wen), 32'd0);
    check("ill_pipe_pulse", 32'(illegal_rd), 32'd1);
    tick();
    check("ill_pipe_end", 32'(illegal_rd), 32'd0);
    ll(5'd0, 32'h9); #1;
    check("x0_ready", 32'(ll_ready), 32'd1);
    tick(); idle();
    check("x0_count", 32'(fifo_count), 32'd0);
    check("x0_no_ill", 32'(illegal_rd), 32'd0);
    tick();
    check("x0_no_wen", 32'(rf_wen), 32'd0);
    pipe(5'd20, 32'h1); ll(5'd16, 32'h2); tick(); idle();
    check("ill_both_pulse", 32'(illegal_rd), 32'd1);
    check("ill_both_count", 32'(fifo_count), 32'd0);
    tick();
    check("ill_both_end", 32'(illegal_rd), 32'd0);

    // Scoreboard collision: pop of x4 and reissue of x4 in one cycle
    issue(5'd4); tick(); idle();
    ll(5'd4, 32'h44); tick(); idle();
    issue(5'd4); tick(); idle(); rs2 = 5'd4; #1;
    check("col_wen", 32'(rf_wen), 32'd1);
    check("col_rd", 32'(rf_rd), 32'd4);
    check("col_data", rf_w_data, 32'h44);
    check("col_busy", 32'(rs2_busy), 32'd1);
    rs1 = 5'd20; #1;
    check("rs_hi_not_busy", 32'(rs1_busy), 32'd0);

    // Reset mid-operation
    issue(5'd9); tick(); idle();
    pipe(5'd1, 32'h1); ll(5'd10, 32'h10); tick();
    pipe(5'd2, 32'h2); ll(5'd11, 32'h11); tick(); idle(); rs1 = 5'd9; #1;
    check("mr_full", 32'(fifo_count), 32'd2);
    check("mr_busy_pre", 32'(rs1_busy), 32'd1);
    nRST = 1'b0; #1;
    check("mr_ready_rst", 32'(ll_ready), 32'd0);
    tick();
    check("mr_count", 32'(fifo_count), 32'd0);
    check("mr_busy9", 32'(rs1_busy), 32'd0);
    check("mr_busy4", 32'(rs2_busy), 32'd0);
    check("mr_wen", 32'(rf_wen), 32'd0);
    nRST = 1'b1; #1;
    check("mr_ready_after", 32'(ll_ready), 32'd1);
    tick();
    check("mr_no_write", 32'(rf_wen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
